// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS32 core: fetch FSM state type, jump opcodes and
// reset/trap vectors.
package cpu_pkg;

  typedef enum logic [1:0] {
    StReset,
    StReq,
    StHold
  } ifetch_state_t;

  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0000_0180;

endpackage

// File: rtl/ifetch_npc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > sequential.
// IFETCH_MISALIGN_TRAP_EN redirects misaligned jr targets to TRAP_PC.
module ifetch_npc
  import cpu_pkg::*;
(
  input  logic [31:0] link_addr_i,
  input  logic [25:0] instr_index_i,
  input  logic        branch_i,
  input  logic        nbranch_i,
  input  logic        jmp_i,
  input  logic        jal_i,
  input  logic        jr_i,
  input  logic        zero_i,
  input  logic [31:0] addr_result_i,
  input  logic [31:0] rd1_i,
  output logic [31:0] next_pc_o,
  output logic        trap_o
);

  logic        taken;
  logic [31:0] npc;

  always_comb begin
    taken  = (branch_i & zero_i) | (nbranch_i & ~zero_i);
    trap_o = 1'b0;
    npc    = link_addr_i;
    if (jr_i) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (rd1_i[1:0] != 2'b00) begin
        npc    = TRAP_PC;
        trap_o = 1'b1;
      end else begin
        npc = rd1_i;
      end
`else
      npc = rd1_i;
`endif
    end else if (jmp_i || jal_i) begin
      npc = {link_addr_i[31:28], instr_index_i, 2'b00};
    end else if (taken) begin
      npc = addr_result_i;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign next_pc_o = npc;
`else
  // Without the trap, the PC is kept word-aligned by dropping the low bits.
  assign next_pc_o = npc & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/ifetch32.sv
// MIPS32 instruction-fetch stage: PC register, req/ack fetch FSM and next-PC commit.
// Optional misaligned-jr trap enabled by IFETCH_MISALIGN_TRAP_EN.
module ifetch32
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jr,
  input  logic        Zero,
  input  logic [31:0] Addr_result,
  input  logic [31:0] Read_data_1,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        fetch_fault
);

  ifetch_state_t state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic [31:0]   next_pc;
  logic          trap;

  assign link_addr = pc_q + 32'd4;

  ifetch_npc u_npc (
    .link_addr_i   (link_addr),
    .instr_index_i (instr_q[25:0]),
    .branch_i      (Branch),
    .nbranch_i     (nBranch),
    .jmp_i         (Jmp),
    .jal_i         (Jal),
    .jr_i          (Jr),
    .zero_i        (Zero),
    .addr_result_i (Addr_result),
    .rd1_i         (Read_data_1),
    .next_pc_o     (next_pc),
    .trap_o        (trap)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    unique case (state_q)
      StReset: state_d = StReq;
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          // Fault tracks only the most recent commit.
          fault_d = trap;
          state_d = StReq;
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StReset;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req    = (state_q == StReq);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_ifetch32.sv
// Scoreboard bench for ifetch32: directed spec vectors plus randomized control flow
// against an arithmetic next-PC model.
module tb_ifetch32;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        advance = 1'b0;
  logic        Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
  logic [31:0] Addr_result = 32'h0, Read_data_1 = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction, pc, link_addr;
  logic        inst_valid, fetch_fault;

  always #5 clk = ~clk;

  ifetch32 dut (
    .clk         (clk),
    .reset       (reset),
    .advance     (advance),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .Jmp         (Jmp),
    .Jal         (Jal),
    .Jr          (Jr),
    .Zero        (Zero),
    .Addr_result (Addr_result),
    .Read_data_1 (Read_data_1),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .pc          (pc),
    .link_addr   (link_addr),
    .fetch_fault (fetch_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_pc = 32'h0;
  logic [31:0] model_instr = 32'h0;
  logic        model_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] ins,
                                          input logic br, input logic nbr, input logic j,
                                          input logic jl, input logic jr, input logic z,
                                          input logic [31:0] ar, input logic [31:0] rd1,
                                          output logic trap);
    logic [31:0] seq;
    logic [31:0] r;
    seq  = cur + 32'd4;
    trap = 1'b0;
    if (jr) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (rd1 % 4 != 0) begin
        r    = TRAP_PC;
        trap = 1'b1;
      end else begin
        r = rd1;
      end
`else
      r = rd1 - (rd1 % 4);
`endif
    end else if (j || jl) begin
      r = (seq / 32'h1000_0000) * 32'h1000_0000 + (ins % 32'h0400_0000) * 4;
    end else if ((br && z) || (nbr && !z)) begin
      r = ar;
    end else begin
      r = seq;
    end
`ifndef IFETCH_MISALIGN_TRAP_EN
    r = r - (r % 4);
`endif
    return r;
  endfunction

  // Monitor: each time a new fetched word appears, pop and compare.
  initial begin
    logic seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (inst_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_fetch: got instruction %h, required no fetch", instruction);
        end else begin
          e = exp_q.pop_front();
          chk("mon_pc", pc, e.pc);
          chk("mon_instr", instruction, e.instr);
          chk("mon_link", link_addr, e.pc + 32'd4);
          chk("mon_fault", {31'h0, fetch_fault}, {31'h0, e.fault});
          chk("mon_req_low", {31'h0, imem_req}, 32'h0);
        end
      end
      if (!inst_valid) seen = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] data, input int lat);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'h0, imem_req}, 32'h1);
    for (int i = 0; i < lat; i++) begin
      chk("wait_req", {31'h0, imem_req}, 32'h1);
      chk("wait_addr", imem_addr, model_pc);
      chk("wait_no_valid", {31'h0, inst_valid}, 32'h0);
      tick();
    end
    chk("ack_addr", imem_addr, model_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back('{model_pc, data, model_fault});
    model_instr = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic adv(input logic br, input logic nbr, input logic j, input logic jl,
                     input logic jr, input logic z, input logic [31:0] ar,
                     input logic [31:0] rd1);
    logic        trap;
    logic [31:0] np;
    chk("hold_before_adv", {31'h0, inst_valid}, 32'h1);
    np          = ref_npc(model_pc, model_instr, br, nbr, j, jl, jr, z, ar, rd1, trap);
    Branch      = br;
    nBranch     = nbr;
    Jmp         = j;
    Jal         = jl;
    Jr          = jr;
    Zero        = z;
    Addr_result = ar;
    Read_data_1 = rd1;
    advance     = 1'b1;
    tick();
    advance     = 1'b0;
    {Branch, nBranch, Jmp, Jal, Jr, Zero} = 6'b0;
    Addr_result = $urandom;
    Read_data_1 = $urandom;
    model_pc    = np;
    model_fault = trap;
    chk("adv_pc", pc, model_pc);
    chk("adv_valid_clr", {31'h0, inst_valid}, 32'h0);
    chk("adv_req", {31'h0, imem_req}, 32'h1);
    chk("adv_fault", {31'h0, fetch_fault}, {31'h0, model_fault});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd1;
    // Reset state
    tick();
    tick();
    chk("rst_pc", pc, RESET_PC);
    chk("rst_link", link_addr, RESET_PC + 32'd4);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_fault", {31'h0, fetch_fault}, 32'h0);
    reset = 1'b1;
    tick();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    fetch(32'h0043_3820, 0);

    // Sequential with 3 wait states
    adv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("seq_pc4", pc, 32'h4);
    fetch($urandom, 3);
    adv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    fetch(32'h0C00_0010, 0);
    chk("jal_link", link_addr, 32'hC);
    adv(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    chk("jal_pc", pc, 32'h40);
    fetch($urandom, 1);
    adv(1, 0, 0, 0, 0, 1, 32'h80, 32'h0);
    chk("beq_taken", pc, 32'h80);
    fetch($urandom, 2);
    adv(0, 1, 0, 0, 0, 1, 32'h400, 32'h0);
    chk("bne_untaken", pc, 32'h84);
    fetch($urandom, 0);
    adv(0, 0, 0, 0, 1, 0, 32'h0, 32'h100);
    chk("jr_pc", pc, 32'h100);
    fetch(32'h0800_0005, 0);
    adv(0, 0, 1, 0, 1, 0, 32'h0, 32'h200);
    chk("jr_beats_j", pc, 32'h200);
    fetch($urandom, 0);

    // Wrap-around
    adv(0, 0, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC);
    fetch($urandom, 0);
    chk("wrap_link", link_addr, 32'h0);
    adv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    fetch($urandom, 0);

    // Misaligned jr
    adv(0, 0, 0, 0, 1, 0, 32'h0, 32'h102);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("mis_pc", pc, TRAP_PC);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
`else
    chk("mis_pc", pc, 32'h100);
    chk("mis_fault", {31'h0, fetch_fault}, 32'h0);
`endif
    fetch($urandom, 1);
    adv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("mis_fault_clr", {31'h0, fetch_fault}, 32'h0);

    // advance in REQ is ignored
    advance     = 1'b1;
    Jr          = 1'b1;
    Read_data_1 = 32'h0000_0700;
    tick();
    advance = 1'b0;
    Jr      = 1'b0;
    chk("stray_adv_pc", pc, model_pc);
    chk("stray_adv_req", {31'h0, imem_req}, 32'h1);
    fetch(32'h1234_5678, 0);

    // ack in HOLD is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("stray_ack_instr", instruction, 32'h1234_5678);
    chk("stray_ack_pc", pc, model_pc);
    chk("stray_ack_valid", {31'h0, inst_valid}, 32'h1);

    // Reset while REQ waits; late ack is dropped
    adv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_pc", pc, RESET_PC);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'h0, inst_valid}, 32'h0);
    chk("late_ack_instr", instruction, 32'h0);
    chk("late_ack_req", {31'h0, imem_req}, 32'h1);
    model_pc    = RESET_PC;
    model_fault = 1'b0;
    fetch($urandom, 0);

    // Randomized control flow
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 2)) tick();
      rd1 = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rd1 = rd1 | 32'($urandom_range(1, 3));
      adv($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          $urandom & 32'hFFFF_FFFC, rd1);
      fetch($urandom, $urandom_range(0, 3));
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
